random_delay_timer: RTL and testbench
=====================================

// Module: random_delay_timer
// PURPOSE
//   Parametrised random-delay generator for the reaction timer. A free-running Fibonacci
//   LFSR with configurable width, taps and seed supplies a random value; on start it is
//   mapped to MIN_DELAY + lfsr[RAND_BITS-1:0] with saturation and counted down on tick.
//   One done pulse marks expiry. Sits between the button/control FSM and the display path.
// PARAMETERS
//   WIDTH      12       LFSR, delay and counter width (>= 4)
//   TAPS       12'hC00  feedback mask; feedback = XOR of out bits where TAPS bit = 1
//   SEED       12'hAAA  reset/fallback LFSR state; must be nonzero
//   RAND_BITS  10       LFSR LSBs added to MIN_DELAY (1..WIDTH)
//   MIN_DELAY  256      minimum delay in ticks; must be >= 1
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-low reset
//   en         in   1      LFSR advance enable
//   seed_load  in   1      load seed_in into LFSR
//   seed_in    in   WIDTH  seed value; zero replaced by SEED
//   start      in   1      begin a delay (accepted only when idle)
//   abort      in   1      cancel active delay, no done
//   tick       in   1      count-down enable (e.g. 1 kHz strobe)
//   lfsr_out   out  WIDTH  current LFSR state
//   delay_val  out  WIDTH  delay captured at last accepted start
//   count      out  WIDTH  remaining ticks
//   busy       out  1      high while counting
//   done       out  1      one-cycle expiry pulse
// BEHAVIOUR
//   - Reset (reset==0 at clk edge): lfsr_out=SEED, delay_val=0, count=0, busy=0, done=0,
//     state=IDLE. Overrides all other inputs. Mid-count reset: no done, busy drops next edge.
//   - LFSR: next = {out[WIDTH-2:0], ^(out & TAPS)}. Priority: seed_load > en > hold.
//     Zero seed_in loads SEED. All-zero state is never held: if out==0, next = SEED.
//     The LFSR runs independently of the FSM; seed_load while busy leaves count alone.
//   - Delay map: sum = MIN_DELAY + out[RAND_BITS-1:0] in WIDTH+1 bits; delay =
//     (sum > 2^WIDTH-1) ? 2^WIDTH-1 : sum. Uses lfsr_out before that cycle's update.
//   - FSM states IDLE, COUNT, DONE; all outputs registered; busy = (state==COUNT).
//     IDLE : start -> delay_val<=delay, count<=delay, COUNT. abort ignored here.
//     COUNT: abort -> count<=0, IDLE (beats a same-cycle final tick; no done).
//            else tick & count==1 -> count<=0, DONE; tick & count>1 -> count-1.
//            start ignored. No tick -> hold.
//     DONE : done=1 for this cycle only; -> IDLE unconditionally. start ignored.
//   - Latency: start at cycle 0; COUNT from cycle 1 with count=D; tick on cycle 0 ignored.
//     With tick held high, done=1 in cycle D+1 and busy low from cycle D+1.
//     Earliest restart: start in cycle D+2 (IDLE again).
//   - Counter never wraps: decrements only in COUNT and stops at 0.
// TESTING
//   1 Reset: hold reset=0 2 cycles with start/en/tick high -> lfsr=0xAAA, busy=0,
//     done=0, count=0, delay_val=0.
//   2 LFSR: en=1 from 0xAAA -> 0x555, 0xAAB, 0x557; en=0 holds; seed_load 0 -> 0xAAA;
//     seed_load 0x001 with en=1 -> 0x001 loaded (load wins).
//   3 Delay/latency: lfsr=0x555, start, tick always 1 -> delay_val=597 (256+0x155),
//     busy 597 cycles, single done pulse exactly 598 cycles after start.
//   4 Saturation: WIDTH=8, MIN_DELAY=200, RAND_BITS=7, TAPS=8'hB8, SEED=8'hFF,
//     seed 0x7F -> delay_val=255, not 71.
//   5 Abort: abort at count==1 with tick=1 -> no done, busy=0, count=0 next cycle;
//     abort in IDLE with start -> start accepted.
//   6 Robustness: start while busy, seed_load mid-count, reset mid-count -> count
//     unaffected by first two; reset clears all outputs, never emits done.

Source files
------------

// File: rtl/random_delay_timer.sv
// Random-delay generator: free-running Fibonacci LFSR picks a delay, which is then
// counted down on tick strobes and announced with a single done pulse.
module random_delay_timer #(
    parameter int unsigned      WIDTH     = 12,
    parameter logic [WIDTH-1:0] TAPS      = 12'hC00,
    parameter logic [WIDTH-1:0] SEED      = 12'hAAA,
    parameter int unsigned      RAND_BITS = 10,
    parameter int unsigned      MIN_DELAY = 256
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             en_i,
    input  logic             seed_load_i,
    input  logic [WIDTH-1:0] seed_in_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             tick_i,
    output logic [WIDTH-1:0] lfsr_out_o,
    output logic [WIDTH-1:0] delay_val_o,
    output logic [WIDTH-1:0] count_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned SUM_W = WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   lfsr_q, lfsr_d;
    logic [WIDTH-1:0]   delay_val_q, delay_val_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               feedback;
    logic [SUM_W-1:0]   sum;
    logic [WIDTH-1:0]   delay;

    // LFSR next state: load beats advance; an all-zero state is replaced by SEED
    always_comb begin
        feedback = ^(lfsr_q & TAPS);
        lfsr_d   = lfsr_q;
        if (seed_load_i) begin
            lfsr_d = (seed_in_i == '0) ? SEED : seed_in_i;
        end else if (lfsr_q == '0) begin
            lfsr_d = SEED;
        end else if (en_i) begin
            lfsr_d = {lfsr_q[WIDTH-2:0], feedback};
        end
    end

    // Delay map with saturation at the counter's full-scale value
    always_comb begin
        sum   = SUM_W'(MIN_DELAY) + SUM_W'(lfsr_q[RAND_BITS-1:0]);
        delay = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    end

    always_comb begin
        state_d     = state_q;
        delay_val_d = delay_val_q;
        count_d     = count_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    delay_val_d = delay;
                    count_d     = delay;
                    state_d     = S_COUNT;
                end
            end
            S_COUNT: begin
                // abort outranks a same-cycle final tick, so no done is produced
                if (abort_i) begin
                    count_d = '0;
                    state_d = S_IDLE;
                end else if (tick_i) begin
                    if (count_q <= WIDTH'(1)) begin
                        count_d = '0;
                        state_d = S_DONE;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
        busy_d = (state_d == S_COUNT);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q     <= S_IDLE;
            lfsr_q      <= SEED;
            delay_val_q <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            delay_val_q <= delay_val_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign lfsr_out_o  = lfsr_q;
    assign delay_val_o = delay_val_q;
    assign count_o     = count_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_random_delay_timer.sv
// Bench for random_delay_timer: directed vectors, expected done events queued and
// matched by a monitor against delay_val and the cycle the pulse appears.
module tb_random_delay_timer;

    typedef struct {
        logic [11:0] dv;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0, seed_load = 1'b0, start = 1'b0, abort = 1'b0, tick = 1'b0;
    logic [11:0] seed_in = '0;
    logic [11:0] lfsr_out, delay_val, count;
    logic        busy, done;

    logic        seed_load8 = 1'b0, start8 = 1'b0;
    logic [7:0]  seed_in8 = '0;
    logic [7:0]  lfsr8, dv8, count8;
    logic        busy8, done8;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    random_delay_timer dut (
        .clk_i(clk), .reset_ni(reset_n), .en_i(en), .seed_load_i(seed_load),
        .seed_in_i(seed_in), .start_i(start), .abort_i(abort), .tick_i(tick),
        .lfsr_out_o(lfsr_out), .delay_val_o(delay_val), .count_o(count),
        .busy_o(busy), .done_o(done)
    );

    random_delay_timer #(
        .WIDTH(8), .TAPS(8'hB8), .SEED(8'hFF), .RAND_BITS(7), .MIN_DELAY(200)
    ) dut8 (
        .clk_i(clk), .reset_ni(reset_n), .en_i(1'b0), .seed_load_i(seed_load8),
        .seed_in_i(seed_in8), .start_i(start8), .abort_i(abort), .tick_i(tick),
        .lfsr_out_o(lfsr8), .delay_val_o(dv8), .count_o(count8),
        .busy_o(busy8), .done_o(done8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("done_within_budget", 32'(done), 32'd1);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                check("done_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("done_delay_val", 32'(delay_val), 32'(e.dv));
                    check("done_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        int c0;
        int k;
        int busy_cnt;

        // Reset dominates start/en/tick
        reset_n = 1'b0; start = 1'b1; en = 1'b1; tick = 1'b1;
        step(2);
        check("rst_lfsr", 32'(lfsr_out), 32'h0AAA);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_delay_val", 32'(delay_val), 32'd0);
        check("rst_lfsr8", 32'(lfsr8), 32'h00FF);
        start = 1'b0; en = 1'b0; tick = 1'b0; reset_n = 1'b1;
        step(1);

        // LFSR sequence, hold, zero-seed fallback, load priority
        en = 1'b1;
        step(1); check("lfsr_1", 32'(lfsr_out), 32'h0555);
        step(1); check("lfsr_2", 32'(lfsr_out), 32'h0AAB);
        step(1); check("lfsr_3", 32'(lfsr_out), 32'h0557);
        en = 1'b0;
        step(1); check("lfsr_hold", 32'(lfsr_out), 32'h0557);
        seed_load = 1'b1; seed_in = 12'h000;
        step(1); check("lfsr_zero_seed", 32'(lfsr_out), 32'h0AAA);
        seed_in = 12'h001; en = 1'b1;
        step(1); check("lfsr_load_wins", 32'(lfsr_out), 32'h0001);
        en = 1'b0;

        // Delay map and latency: 256 + 0x155 = 597, done at start + 598
        seed_in = 12'h555;
        step(1); seed_load = 1'b0;
        check("lfsr_seed555", 32'(lfsr_out), 32'h0555);
        tick = 1'b1; start = 1'b1; c0 = cyc;
        sb.push_back('{12'd597, c0 + 598});
        step(1); start = 1'b0;
        check("t3_busy", 32'(busy), 32'd1);
        check("t3_count", 32'(count), 32'd597);
        check("t3_delay_val", 32'(delay_val), 32'd597);
        busy_cnt = 1; k = 0;
        while (!done && k < 700) begin
            step(1); k++;
            if (busy) busy_cnt++;
        end
        check("t3_done_seen", 32'(done), 32'd1);
        check("t3_busy_cycles", 32'(busy_cnt), 32'd597);
        check("t3_busy_at_done", 32'(busy), 32'd0);
        step(1);
        check("t3_single_pulse", 32'(done), 32'd0);

        // Saturation on the 8-bit variant: 200 + 127 -> 255
        seed_load8 = 1'b1; seed_in8 = 8'h7F;
        step(1); seed_load8 = 1'b0;
        check("t4_lfsr8", 32'(lfsr8), 32'h007F);
        start8 = 1'b1;
        step(1); start8 = 1'b0;
        check("t4_delay_sat", 32'(dv8), 32'd255);
        check("t4_count_sat", 32'(count8), 32'd255);
        check("t4_busy8", 32'(busy8), 32'd1);
        abort = 1'b1;
        step(1); abort = 1'b0;
        check("t4_abort8", 32'(busy8), 32'd0);

        // Abort on the final tick: no done
        seed_load = 1'b1; seed_in = 12'h400;
        step(1); seed_load = 1'b0;
        start = 1'b1;
        step(1); start = 1'b0;
        check("t5_count_start", 32'(count), 32'd256);
        k = 0;
        while (count != 12'd1 && k < 300) begin
            step(1); k++;
        end
        check("t5_reach_one", 32'(count), 32'd1);
        abort = 1'b1;
        step(1); abort = 1'b0;
        check("t5_abort_busy", 32'(busy), 32'd0);
        check("t5_abort_count", 32'(count), 32'd0);
        check("t5_abort_done", 32'(done), 32'd0);
        step(2);
        check("t5_no_late_done", 32'(done), 32'd0);

        // abort in IDLE does not block a start
        abort = 1'b1; start = 1'b1; c0 = cyc;
        sb.push_back('{12'd256, c0 + 257});
        step(1); abort = 1'b0; start = 1'b0;
        check("t5_idle_start_busy", 32'(busy), 32'd1);
        check("t5_idle_start_count", 32'(count), 32'd256);

        // start and seed_load while busy leave the count alone
        step(10);
        start = 1'b1; seed_load = 1'b1; seed_in = 12'h123;
        step(1); start = 1'b0; seed_load = 1'b0;
        check("t6_lfsr_loaded", 32'(lfsr_out), 32'h0123);
        check("t6_count_kept", 32'(count), 32'(256 - (cyc - c0 - 1)));
        check("t6_delay_kept", 32'(delay_val), 32'd256);
        wait_done(300);
        step(1);

        // Reset mid-count clears everything and never yields done
        start = 1'b1;
        step(1); start = 1'b0;
        check("t6_restart_busy", 32'(busy), 32'd1);
        step(5);
        reset_n = 1'b0;
        step(1); reset_n = 1'b1;
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_count", 32'(count), 32'd0);
        check("t6_rst_delay_val", 32'(delay_val), 32'd0);
        check("t6_rst_done", 32'(done), 32'd0);
        check("t6_rst_lfsr", 32'(lfsr_out), 32'h0AAA);
        step(300);
        tick = 1'b0;

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
